// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline register with valid/ready handshake,
// 2-entry skid buffer, synchronous flush and a saturating stall counter.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned LANES  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES*REG_W-1:0]  in_reg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES*REG_W-1:0]  out_reg,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int unsigned DW = LANES * DATA_W;
  localparam int unsigned RW = LANES * REG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Occupancy: EMPTY = main invalid, ONE = main only, FULL = main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            out_valid_q;
  logic            in_ready_q;
  logic [DW-1:0]   main_data_q, skid_data_q;
  logic [RW-1:0]   main_reg_q, skid_reg_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic in_fire_c, out_fire_c;
  logic load_main_in, load_skid_in, load_main_skid;

  assign in_fire_c  = in_valid & in_ready_q;
  assign out_fire_c = out_valid_q & out_ready;

  // Next-state and load-select decode; flush overrides all movement.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire_c) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_fire_c && out_fire_c) begin
          load_main_in = 1'b1;
        end else if (in_fire_c) begin
          load_skid_in = 1'b1;
          state_d      = FULL;
        end else if (out_fire_c) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire_c) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_skid_in   = 1'b0;
      load_main_skid = 1'b0;
    end
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != FULL);
    end
  end

  // Main and skid payload registers; cleared on reset and flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_data_q <= '0;
      main_reg_q  <= '0;
      skid_data_q <= '0;
      skid_reg_q  <= '0;
    end else begin
      if (load_main_in) begin
        main_data_q <= in_data;
        main_reg_q  <= in_reg;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_reg_q  <= skid_reg_q;
      end
      if (load_skid_in) begin
        skid_data_q <= in_data;
        skid_reg_q  <= in_reg;
      end
    end
  end

  // Saturating count of back-pressured cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_reg   = main_reg_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (CNT_W=4 so saturation is reachable).
module tb_pipe_stage_buf;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned LANES  = 2;
  localparam int unsigned CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    reset, flush, in_valid, out_ready;
  logic                    in_ready, out_valid;
  logic [LANES*DATA_W-1:0] in_data, out_data;
  logic [LANES*REG_W-1:0]  in_reg, out_reg;
  logic [CNT_W-1:0]        stall_cnt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  pipe_stage_buf #(
    .DATA_W(DATA_W), .REG_W(REG_W), .LANES(LANES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_reg(in_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_reg(out_reg),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [5:0] r);
    in_valid = 1'b1;
    in_data  = d;
    in_reg   = r;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_reg = '0;
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_reg", 32'(out_reg), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    reset = 1'b0;

    // Single bundle, one-cycle latency.
    out_ready = 1'b1;
    send(16'hA55A, 6'o35);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hA55A);
    chk("single_reg", 32'(out_reg), 32'o35);
    in_valid = 1'b0;
    step();
    chk("single_drain", 32'(out_valid), 32'd0);
    chk("single_hold_data", 32'(out_data), 32'hA55A);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), 6'(i));
      step();
      chk($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("stream_data_%0d", i), 32'(out_data), 32'(i));
      chk($sformatf("stream_ready_%0d", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", 32'(out_valid), 32'd0);

    // Back-pressure: 1 in main, 2 in skid, 3 held upstream.
    out_ready = 1'b0;
    send(16'd1, 6'd1);
    step();
    chk("bp_one_data", 32'(out_data), 32'd1);
    chk("bp_one_ready", 32'(in_ready), 32'd1);
    send(16'd2, 6'd2);
    step();
    chk("bp_full_data", 32'(out_data), 32'd1);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    send(16'd3, 6'd3);
    step();
    chk("bp_hold_data", 32'(out_data), 32'd1);
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_out2_data", 32'(out_data), 32'd2);
    chk("bp_out2_reg", 32'(out_reg), 32'd2);
    chk("bp_out2_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_out3_data", 32'(out_data), 32'd3);
    chk("bp_out3_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Flush while FULL with input offered.
    out_ready = 1'b0;
    send(16'h11, 6'o11);
    step();
    send(16'h22, 6'o22);
    step();
    chk("fl_full_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    send(16'h33, 6'o33);
    step();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_data", 32'(out_data), 32'd0);
    chk("fl_reg", 32'(out_reg), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    // Flush in EMPTY with an accepted input: the input must be dropped.
    send(16'h44, 6'o44);
    step();
    chk("fl_drop_valid", 32'(out_valid), 32'd0);
    chk("fl_drop_data", 32'(out_data), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_after_valid", 32'(out_valid), 32'd0);

    // Stall counter saturation.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sc_rst", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0;
    send(16'h55, 6'o5);
    step();
    chk("sc_first", 32'(stall_cnt), 32'd0);
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) chk("sc_14", 32'(stall_cnt), 32'd14);
      if (k == 15) chk("sc_15", 32'(stall_cnt), 32'd15);
    end
    chk("sc_sat", 32'(stall_cnt), 32'd15);
    chk("sc_still_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sc_flush", 32'(stall_cnt), 32'd15);
    chk("sc_flush_valid", 32'(out_valid), 32'd0);
    step();
    chk("sc_idle", 32'(stall_cnt), 32'd15);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sc_reset", 32'(stall_cnt), 32'd0);

    // Reset while FULL: skid entry must never emerge.
    out_ready = 1'b0;
    send(16'h61, 6'o1);
    step();
    send(16'h62, 6'o2);
    step();
    chk("rf_full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rf_valid", 32'(out_valid), 32'd0);
    chk("rf_ready", 32'(in_ready), 32'd1);
    chk("rf_data", 32'(out_data), 32'd0);
    chk("rf_reg", 32'(out_reg), 32'd0);
    step();
    chk("rf_no_skid_valid", 32'(out_valid), 32'd0);
    chk("rf_no_skid_data", 32'(out_data), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
